load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port: accepts load/store requests from the MIPS execute/memory stage, generates word-aligned memory accesses, performs read-modify-write for sub-word stores, and returns aligned, extended load data. It sits between the pipeline's memory stage and `data_mem`, driving its `addr`, `w_data` and `w_ena` and consuming its asynchronous-read `r_data`.

## Interface
- `ADDR_WIDTH`, 32: byte-address width; memory word address is `ADDR_WIDTH` bits, zero-extended from `byte_addr[ADDR_WIDTH-1:2]`.
- `MEM_WORD`, 32: data word width; only 32 is supported.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; the request is accepted when `req_valid && req_ready` at a rising edge.
- `req_op` in 3: LW=000, LH=001, LHU=010, LB=011, LBU=100, SW=101, SH=110, SB=111.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in MEM_WORD: store data, right-justified for SH/SB.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_data` out MEM_WORD: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned access, valid with `resp_valid`.
- `mem_addr` out ADDR_WIDTH: word address to memory.
- `mem_w_data` out MEM_WORD: write data.
- `mem_w_ena` out 1: write enable.
- `mem_r_data` in MEM_WORD: combinational read data for `mem_addr`.

## Operation
- Byte order is big-endian: offset 0 = bits [31:24], offset 3 = bits [7:0]; halfword offset 0 = [31:16].
- Alignment: LW/SW require `addr[1:0]`=0; LH/LHU/SH require `addr[0]`=0. A misaligned request is accepted, performs no memory access, and goes to RESP with `resp_err`=1.
- FSM states are IDLE, ACCESS, WRITE and RESP.
  - IDLE: on handshake, latch op, offset, wdata and `mem_addr`. Go to RESP if misaligned, WRITE if SW, otherwise ACCESS.
  - ACCESS: `mem_w_ena`=0. Sample `mem_r_data` at the edge. Loads: extract the lane, sign-extend (LH/LB) or zero-extend (LHU/LBU), register it to `resp_data`, then go to RESP. SH/SB: merge the store lane into the sampled word and register it as `mem_w_data`, then go to WRITE.
  - WRITE: `mem_w_ena`=1 for exactly this cycle, with `mem_w_data` = full word (SW) or merged word; then go to RESP.
  - RESP: `resp_valid`=1 for one cycle; then go to IDLE.
- `mem_addr` holds the last latched value outside of accesses.
- `req_ready` and `mem_w_ena` are decoded from the state register, so reset drops them asynchronously.

## Timing
- The handshake occurs at edge 0. Latency from handshake to `resp_valid` high:
  - LW/LH/LHU/LB/LBU and SW: 2 cycles.
  - SH/SB: 3 cycles.
  - Misaligned: 1 cycle.
- Back-to-back throughput: a new request can be accepted in the cycle after RESP (IDLE). No request is overlapped.
- The memory write is committed at the edge ending WRITE. Read data is sampled at the edge ending ACCESS, one full cycle after `mem_addr` is registered.
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `mem_addr`=0, `mem_w_data`=0, `mem_w_ena`=0.
- Reset mid-operation aborts the operation: no response is issued, and a write pending in WRITE is not performed if reset asserts before its edge.
- `req_valid` while busy is ignored and not latched.

## Structure
- Package `mips_mem_pkg` holds the op-code localparams, the FSM state encoding and the `MEM_WORD`=32 constant. `data_mem`-adjacent blocks share this package.
- Sub-module `lsu_byte_lane` is purely combinational and contains the lane extract with sign/zero extension and the store merge.
- The FSM and registers live in `load_store_unit`.

## Test plan
- Preload word 4 = 0x8899AABB.
  - LB at byte addr 0x11 -> `resp_data`=0xFFFFFF99 at +2 cycles, `resp_err`=0.
  - LBU at the same address -> 0x00000099.
  - LH at 0x12 -> 0xFFFFAABB.
  - LW at 0x10 -> 0x8899AABB.
- SW 0x12345678 to 0x20 -> `mem_w_ena` high one cycle with `mem_addr`=8, `resp_valid` at +2 cycles. A following LW at 0x20 returns 0x12345678.
- SB 0x000000EE to 0x23 over word 0x11223344 -> write 0x112233EE at +2 cycles, `resp_valid` at +3 cycles. SH 0xCAFE to 0x20 -> 0xCAFE33EE.
- LW at 0x22 and SH at 0x21 -> `resp_err`=1, `resp_data`=0 at +1 cycle, `mem_w_ena` never asserted, memory unchanged.
- `req_valid` held high with three queued requests -> each is accepted only when `req_ready`=1, and responses arrive in order with no request lost or duplicated.
- Assert `rst_n`=0 while in WRITE for SB -> `mem_w_ena` falls immediately, memory unchanged, no `resp_valid`, and `req_ready`=1 after release.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared op codes, LSU state encoding and word width for data_mem-adjacent blocks
package mips_mem_pkg;

  localparam int MEM_WORD = 32;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary, bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic r;
    r = 1'b0;
    case (op)
      OP_LW, OP_SW:         r = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH: r = off[0];
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - big-endian lane extract with sign/zero extension and sub-word store merge
module lsu_byte_lane (
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);
  import mips_mem_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane (offset 0 is the most significant byte) and extend it.
  always_comb begin
    byte_sel = rdata_i[31:24];
    case (off_i)
      2'd0:    byte_sel = rdata_i[31:24];
      2'd1:    byte_sel = rdata_i[23:16];
      2'd2:    byte_sel = rdata_i[15:8];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    load_data_o = rdata_i;
    case (op_i)
      OP_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data_o = {16'h0000, half_sel};
      OP_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data_o = {24'h000000, byte_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  // Overlay the right-justified store data onto the addressed lane of the sampled word.
  always_comb begin
    merged_o = rdata_i;
    if (op_i == OP_SB) begin
      case (off_i)
        2'd0:    merged_o[31:24] = wdata_i[7:0];
        2'd1:    merged_o[23:16] = wdata_i[7:0];
        2'd2:    merged_o[15:8]  = wdata_i[7:0];
        default: merged_o[7:0]   = wdata_i[7:0];
      endcase
    end else if (op_i == OP_SH) begin
      if (off_i[1]) merged_o[15:0] = wdata_i[15:0];
      else          merged_o[31:16] = wdata_i[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: word accesses, sub-word read-modify-write, load extension
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORD   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MEM_WORD-1:0]   req_wdata,
  output logic                  resp_valid,
  output logic [MEM_WORD-1:0]   resp_data,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WORD-1:0]   mem_w_data,
  output logic                  mem_w_ena,
  input  logic [MEM_WORD-1:0]   mem_r_data
);
  import mips_mem_pkg::*;

  lsu_state_e            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            off_q, off_d;
  logic [MEM_WORD-1:0]   wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_WORD-1:0]   mem_w_data_q, mem_w_data_d;
  logic [MEM_WORD-1:0]   resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;

  logic [MEM_WORD-1:0]   lane_load;
  logic [MEM_WORD-1:0]   lane_merged;
  logic                  req_misaligned;

  lsu_byte_lane u_lane (
    .op_i        (op_q),
    .off_i       (off_q),
    .rdata_i     (mem_r_data),
    .wdata_i     (wdata_q),
    .load_data_o (lane_load),
    .merged_o    (lane_merged)
  );

  assign req_misaligned = is_misaligned(req_op, req_addr[1:0]);

  // Handshake flags and write strobe come straight from the state so reset kills them at once.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign mem_w_ena  = (state_q == ST_WRITE);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_w_data = mem_w_data_q;

  // Next-state and datapath decode for the IDLE -> ACCESS/WRITE -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d        = req_op;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata;
          mem_addr_d  = {2'b00, req_addr[ADDR_WIDTH-1:2]};
          resp_data_d = '0;
          resp_err_d  = req_misaligned;
          if (req_misaligned) begin
            state_d = ST_RESP;
          end else if (req_op == OP_SW) begin
            mem_w_data_d = req_wdata;
            state_d      = ST_WRITE;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (is_store(op_q)) begin
          mem_w_data_d = lane_merged;
          state_d      = ST_WRITE;
        end else begin
          resp_data_d = lane_load;
          state_d     = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LW;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a behavioural memory model
module tb_load_store_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic        mem_w_ena;
  logic [31:0] mem_r_data;

  logic [31:0] tb_mem  [0:63];
  logic [31:0] ref_mem [0:63];

  int tests = 0;
  int fails = 0;

  load_store_unit #(.ADDR_WIDTH(32), .MEM_WORD(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_w_ena  (mem_w_ena),
    .mem_r_data (mem_r_data)
  );

  always #5 clk = ~clk;

  assign mem_r_data = tb_mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_w_ena) tb_mem[mem_addr[5:0]] <= mem_w_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_misaligned(input logic [2:0] op, input logic [31:0] a);
    if (op == LW || op == SW) return (a % 4) != 0;
    if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
    int sb = 8 * (3 - int'(a % 4));
    int sh = 16 * (1 - int'((a % 4) / 2));
    logic [31:0] b = (w >> sb) & 32'hFF;
    logic [31:0] h = (w >> sh) & 32'hFFFF;
    case (op)
      LW:      return w;
      LB:      return (b >= 32'd128) ? b - 32'd256 : b;
      LBU:     return b;
      LH:      return (h >= 32'd32768) ? h - 32'd65536 : h;
      default: return h;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] w, input logic [31:0] d);
    int sb = 8 * (3 - int'(a % 4));
    int sh = 16 * (1 - int'((a % 4) / 2));
    logic [31:0] m;
    if (op == SW) return d;
    if (op == SB) begin
      m = 32'hFF << sb;
      return (w & ~m) | ((d & 32'hFF) << sb);
    end
    m = 32'hFFFF << sh;
    return (w & ~m) | ((d & 32'hFFFF) << sh);
  endfunction

  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic rerr);
    int widx = int'((a / 4) % 64);
    bit mis = ref_misaligned(op, a);
    bit st = (op == SW || op == SH || op == SB);
    logic [31:0] exp_data = (mis || st) ? 32'd0 : ref_load(op, a, ref_mem[widx]);
    logic [31:0] exp_word = (st && !mis) ? ref_store(op, a, ref_mem[widx], wd) : ref_mem[widx];
    int exp_lat = mis ? 1 : ((op == SH || op == SB) ? 3 : 2);
    int exp_wr = (st && !mis) ? 1 : 0;
    int lat = 0, nwr = 0, wcyc = 0;
    logic [31:0] waddr = 0, wdat = 0;
    bit got = 0;
    rdata = 32'hDEADBEEF;
    rerr = 1'bx;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_w_ena) begin nwr++; waddr = mem_addr; wdat = mem_w_data; wcyc = c; end
      if (resp_valid) begin got = 1; lat = c; rdata = resp_data; rerr = resp_err; end
    end
    check("resp_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_data", rdata, exp_data);
    check("resp_err", 32'(rerr), 32'(mis));
    check("write_count", 32'(nwr), 32'(exp_wr));
    if (exp_wr == 1) begin
      check("write_addr", waddr, a >> 2);
      check("write_data", wdat, exp_word);
      check("write_cycle", 32'(wcyc), 32'(exp_lat - 1));
    end
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
    check("mem_word", tb_mem[widx], exp_word);
    ref_mem[widx] = exp_word;
  endtask

  typedef struct { logic [31:0] data; logic err; } exp_t;

  initial begin
    logic [31:0] d;
    logic        e;
    exp_t        q[$];
    exp_t        x;
    logic [2:0]  qop[3];
    logic [31:0] qad[3];
    logic [31:0] qwd[3];
    int          idx, got, acc;
    bit          pend, seen, stray;

    for (int i = 0; i < 64; i++) begin tb_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    tb_mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;

    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_w_data", mem_w_data, 32'd0);
    check("rst_mem_w_ena", 32'(mem_w_ena), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_req(LB, 32'h11, 32'd0, d, e);  check("lb_const", d, 32'hFFFFFF99);
    do_req(LBU, 32'h11, 32'd0, d, e); check("lbu_const", d, 32'h00000099);
    do_req(LH, 32'h12, 32'd0, d, e);  check("lh_const", d, 32'hFFFFAABB);
    do_req(LW, 32'h10, 32'd0, d, e);  check("lw_const", d, 32'h8899AABB);
    do_req(SW, 32'h20, 32'h12345678, d, e);
    do_req(LW, 32'h20, 32'd0, d, e);  check("lw_after_sw", d, 32'h12345678);
    do_req(SW, 32'h20, 32'h11223344, d, e);
    do_req(SB, 32'h23, 32'h000000EE, d, e); check("sb_merge", tb_mem[8], 32'h112233EE);
    do_req(SH, 32'h20, 32'h0000CAFE, d, e); check("sh_merge", tb_mem[8], 32'hCAFE33EE);
    do_req(LW, 32'h22, 32'd0, d, e);  check("lw_mis_err", 32'(e), 32'd1);
    do_req(SH, 32'h21, 32'h0000BEEF, d, e); check("sh_mis_err", 32'(e), 32'd1);
    check("mis_mem_kept", tb_mem[8], 32'hCAFE33EE);

    // Three requests presented with req_valid held high throughout.
    qop[0] = SW;  qad[0] = 32'h40; qwd[0] = 32'hA1B2C3D4;
    qop[1] = LB;  qad[1] = 32'h41; qwd[1] = 32'h0;
    qop[2] = LHU; qad[2] = 32'h43; qwd[2] = 32'h0;
    idx = 0; got = 0; acc = 0; pend = 0; stray = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = qop[0]; req_addr = qad[0]; req_wdata = qwd[0];
    for (int c = 0; c < 60 && got < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (pend) begin
        pend = 0; idx++;
        if (idx < 3) begin req_op = qop[idx]; req_addr = qad[idx]; req_wdata = qwd[idx]; end
        else req_valid = 1'b0;
      end
      if (resp_valid) begin
        if (q.size() == 0) stray = 1;
        else begin
          x = q.pop_front();
          check("queue_data", resp_data, x.data);
          check("queue_err", 32'(resp_err), 32'(x.err));
          got++;
        end
      end
      if (req_valid && req_ready) begin
        x.err = ref_misaligned(req_op, req_addr);
        x.data = (x.err || req_op >= SW) ? 32'd0 : ref_load(req_op, req_addr, ref_mem[(req_addr / 4) % 64]);
        if (!x.err && req_op >= SW)
          ref_mem[(req_addr / 4) % 64] = ref_store(req_op, req_addr, ref_mem[(req_addr / 4) % 64], req_wdata);
        q.push_back(x);
        acc++; pend = 1;
      end
    end
    req_valid = 1'b0;
    check("queue_accepted", 32'(acc), 32'd3);
    check("queue_responses", 32'(got), 32'd3);
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (resp_valid) stray = 1; end
    check("queue_no_extra", 32'(stray), 32'd0);
    check("queue_mem", tb_mem[16], ref_mem[16]);

    // Reset while the sub-word store sits in WRITE.
    @(negedge clk);
    req_valid = 1'b1; req_op = SB; req_addr = 32'h25; req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 4 && !seen; c++) begin @(negedge clk); if (mem_w_ena) seen = 1; end
    check("rstw_reached_write", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstw_w_ena_drop", 32'(mem_w_ena), 32'd0);
    check("rstw_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("rstw_mem_kept", tb_mem[9], ref_mem[9]);
    @(negedge clk); rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (resp_valid) stray = 1; end
    check("rstw_no_resp", 32'(stray), 32'd0);
    check("rstw_ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < 40; i++)
      do_req(3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom, d, e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
